id_stage: RTL

- Registered, parametrised instruction-decode stage between if_id and id_ex.
- Decodes the RV32I/RV64I integer ALU subset: OP-IMM, OP, LUI and AUIPC.
- Reads the register file and issues operands, an ALU op code and writeback control to EX through a valid/ready pipeline register.
- Adds a RAW interlock against the instruction in EX, a flush input, and illegal-instruction flagging.

---
 rtl/id_stage_pkg.sv | 71 +++++++
 rtl/id_decode.sv | 119 +++++++++++
 rtl/id_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: opcodes, funct3/funct7 codes, ALU op codes and operand-select
// types shared by the decode stage and its decoder.
package id_stage_pkg;

    // Major opcodes of the integer ALU subset
    localparam logic [6:0] INST_TYPE_I = 7'b0010011;   // OP-IMM
    localparam logic [6:0] INST_TYPE_R = 7'b0110011;   // OP
    localparam logic [6:0] INST_LUI    = 7'b0110111;
    localparam logic [6:0] INST_AUIPC  = 7'b0010111;

    // OP-IMM funct3
    localparam logic [2:0] INST_ADDI  = 3'b000;
    localparam logic [2:0] INST_SLLI  = 3'b001;
    localparam logic [2:0] INST_SLTI  = 3'b010;
    localparam logic [2:0] INST_SLTIU = 3'b011;
    localparam logic [2:0] INST_XORI  = 3'b100;
    localparam logic [2:0] INST_SRI   = 3'b101;
    localparam logic [2:0] INST_ORI   = 3'b110;
    localparam logic [2:0] INST_ANDI  = 3'b111;

    // OP funct3
    localparam logic [2:0] INST_ADD_SUB = 3'b000;
    localparam logic [2:0] INST_SLL     = 3'b001;
    localparam logic [2:0] INST_SLT     = 3'b010;
    localparam logic [2:0] INST_SLTU    = 3'b011;
    localparam logic [2:0] INST_XOR     = 3'b100;
    localparam logic [2:0] INST_SR      = 3'b101;
    localparam logic [2:0] INST_OR      = 3'b110;
    localparam logic [2:0] INST_AND     = 3'b111;

    // funct7: base encoding and the alternate one used by SUB/SRA/SRAI
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Where operand 1 comes from
    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_RS1  = 2'd1,
        OP1_PC   = 2'd2
    } op1_sel_e;

    // funct3 -> ALU op; alt selects SUB over ADD and SRA over SRL
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            INST_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            INST_SLL:     op = ALU_SLL;
            INST_SLT:     op = ALU_SLT;
            INST_SLTU:    op = ALU_SLTU;
            INST_XOR:     op = ALU_XOR;
            INST_SR:      op = alt ? ALU_SRA : ALU_SRL;
            INST_OR:      op = ALU_OR;
            default:      op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_decode.sv
// id_decode: purely combinational decoder for OP-IMM, OP, LUI and AUIPC.
// Produces source usage, immediate, ALU op, writeback enable and the illegal
// flag. Illegal or unknown encodings decode to "no sources, imm 0, ADD, no wen".
module id_decode
    import id_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic [31:0]         inst,
    output logic                use_rs1,
    output logic                use_rs2,
    output op1_sel_e            op1_sel,
    output logic                op2_imm,
    output logic [XLEN-1:0]     imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                wen,
    output logic                illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_shamt;
    logic            shift_base;
    logic            shift_alt;
    logic            r_alt;
    logic            legal;
    alu_op_e         alu_sel;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign r_alt  = (funct7 == FUNCT7_ALT);
    assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};

    // Shift amount width and the upper funct field depend on XLEN
    if (XLEN == 64) begin : g_rv64
        assign imm_shamt  = XLEN'(inst[25:20]);
        assign shift_base = (inst[31:26] == FUNCT7_BASE[6:1]);
        assign shift_alt  = (inst[31:26] == FUNCT7_ALT[6:1]);
        assign imm_u      = XLEN'({{32{inst[31]}}, inst[31:12], 12'b0});
    end else begin : g_rv32
        assign imm_shamt  = XLEN'(inst[24:20]);
        assign shift_base = (inst[31:25] == FUNCT7_BASE);
        assign shift_alt  = (inst[31:25] == FUNCT7_ALT);
        assign imm_u      = XLEN'({inst[31:12], 12'b0});
    end

    // Opcode/funct decode; anything not recognised falls back to the illegal defaults
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        op1_sel = OP1_ZERO;
        op2_imm = 1'b1;
        imm     = '0;
        alu_sel = ALU_ADD;
        legal   = 1'b0;
        case (opcode)
            INST_TYPE_I: begin
                op1_sel = OP1_RS1;
                use_rs1 = 1'b1;
                case (funct3)
                    INST_SLLI: begin
                        legal   = shift_base;
                        alu_sel = ALU_SLL;
                        imm     = imm_shamt;
                    end
                    INST_SRI: begin
                        legal   = shift_base || shift_alt;
                        alu_sel = alu_from_funct3(funct3, shift_alt);
                        imm     = imm_shamt;
                    end
                    default: begin
                        legal   = 1'b1;
                        alu_sel = alu_from_funct3(funct3, 1'b0);
                        imm     = imm_i;
                    end
                endcase
            end
            INST_TYPE_R: begin
                legal   = (funct7 == FUNCT7_BASE) ||
                          (r_alt && (funct3 == INST_ADD_SUB || funct3 == INST_SR));
                alu_sel = alu_from_funct3(funct3, r_alt);
                op1_sel = OP1_RS1;
                op2_imm = 1'b0;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            INST_LUI: begin
                legal = 1'b1;
                imm   = imm_u;
            end
            INST_AUIPC: begin
                legal   = 1'b1;
                op1_sel = OP1_PC;
                imm     = imm_u;
            end
            default: ;
        endcase
        if (!legal) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            op1_sel = OP1_ZERO;
            op2_imm = 1'b1;
            imm     = '0;
            alu_sel = ALU_ADD;
        end
    end

    assign alu_op  = ALU_OP_W'(alu_sel);
    assign illegal = !legal;
    assign wen     = legal && (rd != 5'd0);

endmodule

// File: rtl/id_stage.sv
// id_stage: registered instruction-decode stage between if_id and id_ex.
// Reads the register file combinationally, builds operands and writeback
// control, and hands them to EX through a valid/ready pipeline register.
// A RAW interlock against the EX-stage instruction stalls acceptance unless
// the ID_BYPASS_EN macro is defined, in which case the EX result is forwarded.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           inst_i,
    input  logic [XLEN-1:0]       instaddr_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] rs1_addr_o,
    output logic [REG_ADDR_W-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic                  ex_wen_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [XLEN-1:0]       ex_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           inst_o,
    output logic [XLEN-1:0]       instaddr_o,
    output logic [XLEN-1:0]       op1_o,
    output logic [XLEN-1:0]       op2_o,
    output logic [ALU_OP_W-1:0]   alu_op_o,
    output logic                  regs_wen_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  illegal_o
);

    // Decoder results
    logic                  use_rs1;
    logic                  use_rs2;
    op1_sel_e              op1_sel;
    logic                  op2_imm;
    logic [XLEN-1:0]       imm;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic                  dec_wen;
    logic                  dec_illegal;

    // Per-source view: index 0 is rs1, index 1 is rs2
    logic [1:0]            src_used;
    logic [1:0]            src_match;
    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [XLEN-1:0]       src_rf   [2];
    logic [XLEN-1:0]       src_val  [2];

    logic                  hazard;
    logic                  fire;
    logic [XLEN-1:0]       op1_next;
    logic [XLEN-1:0]       op2_next;

    // Pipeline register
    logic                  out_valid_reg;
    logic [31:0]           inst_reg;
    logic [XLEN-1:0]       instaddr_reg;
    logic [XLEN-1:0]       op1_reg;
    logic [XLEN-1:0]       op2_reg;
    logic [ALU_OP_W-1:0]   alu_op_reg;
    logic                  regs_wen_reg;
    logic [REG_ADDR_W-1:0] rd_addr_reg;
    logic                  illegal_reg;

    id_decode #(
        .XLEN     (XLEN),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .inst    (inst_i),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .op1_sel (op1_sel),
        .op2_imm (op2_imm),
        .imm     (imm),
        .alu_op  (dec_alu_op),
        .wen     (dec_wen),
        .illegal (dec_illegal)
    );

    assign src_used  = {use_rs2, use_rs1};
    assign src_rf[0] = rs1_data_i;
    assign src_rf[1] = rs2_data_i;

    // Source addresses are only driven for sources the instruction reads, so
    // unused fields never produce a false RAW match.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        localparam int FIELD_LSB = 15 + 5 * gi;
        assign src_addr[gi]  = src_used[gi] ? REG_ADDR_W'(inst_i[FIELD_LSB +: 5]) : '0;
        assign src_match[gi] = src_used[gi] && ex_wen_i && (ex_rd_i != '0) &&
                               (src_addr[gi] == ex_rd_i);
`ifdef ID_BYPASS_EN
        assign src_val[gi] = src_match[gi] ? ex_data_i : src_rf[gi];
`else
        assign src_val[gi] = src_rf[gi];
`endif
    end

`ifdef ID_BYPASS_EN
    assign hazard = 1'b0;
`else
    assign hazard = |src_match;
    logic unused_ex_data;
    assign unused_ex_data = ^ex_data_i;
`endif

    assign rs1_addr_o = src_addr[0];
    assign rs2_addr_o = src_addr[1];

    assign in_ready_o = !flush_i && !hazard && (!out_valid_reg || out_ready_i);
    assign fire       = in_valid_i && in_ready_o;

    // Operand muxes
    always_comb begin
        op1_next = '0;
        case (op1_sel)
            OP1_RS1: op1_next = src_val[0];
            OP1_PC:  op1_next = instaddr_i;
            default: op1_next = '0;
        endcase
        op2_next = op2_imm ? imm : src_val[1];
    end

    // Pipeline register: flush kills valid, fire loads, a drained payload clears valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_reg <= 1'b0;
            inst_reg      <= '0;
            instaddr_reg  <= '0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            alu_op_reg    <= '0;
            regs_wen_reg  <= 1'b0;
            rd_addr_reg   <= '0;
            illegal_reg   <= 1'b0;
        end else if (flush_i) begin
            out_valid_reg <= 1'b0;
        end else if (fire) begin
            out_valid_reg <= 1'b1;
            inst_reg      <= inst_i;
            instaddr_reg  <= instaddr_i;
            op1_reg       <= op1_next;
            op2_reg       <= op2_next;
            alu_op_reg    <= dec_alu_op;
            regs_wen_reg  <= dec_wen;
            rd_addr_reg   <= REG_ADDR_W'(inst_i[11:7]);
            illegal_reg   <= dec_illegal;
        end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_reg;
    assign inst_o      = inst_reg;
    assign instaddr_o  = instaddr_reg;
    assign op1_o       = op1_reg;
    assign op2_o       = op2_reg;
    assign alu_op_o    = alu_op_reg;
    assign regs_wen_o  = regs_wen_reg;
    assign rd_addr_o   = rd_addr_reg;
    assign illegal_o   = illegal_reg;

endmodule
